// File: rtl/sdram_axi_pkg.sv
// Shared AXI constants and fetch FSM state type for the SDRAM line fetcher.
package sdram_axi_pkg;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [31:0] AXI_4K_BYTES   = 32'd4096;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StData,
    StDone
  } fetch_state_e;

endpackage

// File: rtl/sdram_line_fifo.sv
// First-word fall-through FIFO holding fetched pixel words.
module sdram_line_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [Width-1:0]       data_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       data_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] Full = (AW+1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != Full) || do_pop);

  // Occupancy next state; simultaneous push and pop cancel.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointer and count registers; pointers wrap at the power-of-two depth.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/sdram_axi_line_fetch.sv
// Fetches one line of 32-bit words over AXI4 read bursts into a pixel FIFO.
// Optional SDRAM_LINE_FETCH_STATS_EN adds a consumer-underrun cycle counter.
module sdram_axi_line_fetch
  import sdram_axi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned BURST_LEN  = 16,
  parameter logic [3:0]  AXI_ID     = 4'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic [15:0] line_words_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
`ifdef SDRAM_LINE_FETCH_STATS_EN
  output logic [15:0] underrun_cnt_o,
`endif
  output logic        pix_valid_o,
  input  logic        pix_ready_i,
  output logic [31:0] pix_data_o,
  output logic        outport_arvalid_o,
  input  logic        outport_arready_i,
  output logic [31:0] outport_araddr_o,
  output logic [3:0]  outport_arid_o,
  output logic [7:0]  outport_arlen_o,
  output logic [1:0]  outport_arburst_o,
  input  logic        outport_rvalid_i,
  output logic        outport_rready_o,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i,
  input  logic [3:0]  outport_rid_i,
  input  logic        outport_rlast_i,
  output logic        outport_awvalid_o,
  output logic [31:0] outport_awaddr_o,
  output logic [3:0]  outport_awid_o,
  output logic [7:0]  outport_awlen_o,
  output logic [1:0]  outport_awburst_o,
  output logic        outport_wvalid_o,
  output logic [31:0] outport_wdata_o,
  output logic [3:0]  outport_wstrb_o,
  output logic        outport_wlast_o,
  output logic        outport_bready_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [15:0]  remaining_q, remaining_d;
  logic         err_q, err_d;
  logic [12:0]  page_words;
  logic [16:0]  burst_len;
  logic [16:0]  free_words;
  logic [CntW-1:0] fifo_count;
  logic         fifo_empty;
  logic         start_accept, ar_valid, r_ready, beat, bad_beat;
  logic         unused_ok;

  // Read ID is never checked and low address bits are forced to zero.
  assign unused_ok = ^{outport_rid_i, base_addr_i[1:0]};

  // Words left before the 4 KB page boundary; always at least one.
  assign page_words = 13'((AXI_4K_BYTES - {20'd0, addr_q[11:0]}) >> 2);

  // Burst length: limited by BURST_LEN, words remaining and the page boundary.
  always_comb begin
    burst_len = 17'(BURST_LEN);
    if ({1'b0, remaining_q} < burst_len) burst_len = {1'b0, remaining_q};
    if ({4'd0, page_words} < burst_len)  burst_len = {4'd0, page_words};
  end

  assign free_words   = 17'(FIFO_DEPTH) - 17'(fifo_count);
  assign start_accept = (state_q == StIdle) && start_i;
  assign beat         = r_ready && outport_rvalid_i;
  assign bad_beat     = beat && (outport_rresp_i != AXI_RESP_OKAY);

  // Fetch FSM next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    err_d       = err_q;
    ar_valid    = 1'b0;
    r_ready     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_accept) begin
          err_d = 1'b0;
          if (line_words_i != 16'd0) begin
            addr_d      = {base_addr_i[31:2], 2'b00};
            remaining_d = line_words_i;
            state_d     = StReq;
          end else begin
            state_d = StDone;
          end
        end
      end
      StReq: begin
        // Free space only grows while here, so arvalid holds once raised.
        ar_valid = (free_words >= burst_len);
        if (ar_valid && outport_arready_i) begin
          addr_d      = addr_q + {13'd0, burst_len, 2'b00};
          remaining_d = remaining_q - burst_len[15:0];
          state_d     = StData;
        end
      end
      StData: begin
        r_ready = 1'b1;
        if (bad_beat) err_d = 1'b1;
        if (beat && outport_rlast_i) begin
          state_d = (remaining_q != 16'd0) ? StReq : StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM and fetch context registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      err_q       <= err_d;
    end
  end

  sdram_line_fifo #(
    .Width (32),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_i),
    .push_i  (beat),
    .data_i  (outport_rdata_i),
    .pop_i   (pix_ready_i),
    .data_o  (pix_data_o),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign busy_o      = (state_q == StReq) || (state_q == StData);
  assign done_o      = (state_q == StDone);
  // Error is visible in the same cycle as the failing beat.
  assign err_o       = err_q || bad_beat;
  assign pix_valid_o = !fifo_empty;

  assign outport_arvalid_o = ar_valid;
  assign outport_araddr_o  = addr_q;
  assign outport_arid_o    = AXI_ID;
  assign outport_arlen_o   = (state_q == StReq) ? 8'(burst_len - 17'd1) : 8'd0;
  assign outport_arburst_o = AXI_BURST_INCR;
  assign outport_rready_o  = r_ready;

  assign outport_awvalid_o = 1'b0;
  assign outport_awaddr_o  = '0;
  assign outport_awid_o    = '0;
  assign outport_awlen_o   = '0;
  assign outport_awburst_o = '0;
  assign outport_wvalid_o  = 1'b0;
  assign outport_wdata_o   = '0;
  assign outport_wstrb_o   = '0;
  assign outport_wlast_o   = 1'b0;
  assign outport_bready_o  = 1'b1;

`ifdef SDRAM_LINE_FETCH_STATS_EN
  logic [15:0] underrun_q;

  // Saturating count of fetch cycles with the consumer starved.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      underrun_q <= '0;
    end else if (start_accept) begin
      underrun_q <= '0;
    end else if (busy_o && !pix_valid_o && (underrun_q != 16'hFFFF)) begin
      underrun_q <= underrun_q + 16'd1;
    end
  end

  assign underrun_cnt_o = underrun_q;
`endif

endmodule

// File: tb/tb_sdram_axi_line_fetch.sv
// Scoreboard bench for sdram_axi_line_fetch with a behavioural AXI read slave.
module tb_sdram_axi_line_fetch;

  localparam int unsigned Depth = 64;
  localparam int unsigned Burst = 16;
  localparam logic [3:0]  Id    = 4'h5;

  typedef struct {
    logic [31:0] addr;
    int unsigned len;
  } burst_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] line_words = '0;
  logic        busy, done, err, pix_valid;
  logic        pix_ready = 1'b0;
  logic [31:0] pix_data;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic [3:0]  rid = Id;
  logic        rlast = 1'b0;
  logic        awvalid, wvalid, wlast, bready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  awid, wstrb;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
`ifdef SDRAM_LINE_FETCH_STATS_EN
  logic [15:0] underrun_cnt;
`endif

  int total = 0;
  int bad = 0;

  burst_t      exp_ar[$];
  logic [31:0] exp_pix[$];

  bit ar_rand = 1'b0;
  bit r_rand = 1'b0;
  int pop_mode = 1;
  int pop_limit = 0;
  int err_at = -1;
  bit mon_idle = 1'b1;
  int occ = 0;
  int ar_total = 0;
  int pop_total = 0;
  int beats_total = 0;

  always #5 clk = ~clk;

  sdram_axi_line_fetch #(
    .FIFO_DEPTH (Depth),
    .BURST_LEN  (Burst),
    .AXI_ID     (Id)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_n),
    .start_i           (start),
    .base_addr_i       (base_addr),
    .line_words_i      (line_words),
    .busy_o            (busy),
    .done_o            (done),
    .err_o             (err),
`ifdef SDRAM_LINE_FETCH_STATS_EN
    .underrun_cnt_o    (underrun_cnt),
`endif
    .pix_valid_o       (pix_valid),
    .pix_ready_i       (pix_ready),
    .pix_data_o        (pix_data),
    .outport_arvalid_o (arvalid),
    .outport_arready_i (arready),
    .outport_araddr_o  (araddr),
    .outport_arid_o    (arid),
    .outport_arlen_o   (arlen),
    .outport_arburst_o (arburst),
    .outport_rvalid_i  (rvalid),
    .outport_rready_o  (rready),
    .outport_rdata_i   (rdata),
    .outport_rresp_i   (rresp),
    .outport_rid_i     (rid),
    .outport_rlast_i   (rlast),
    .outport_awvalid_o (awvalid),
    .outport_awaddr_o  (awaddr),
    .outport_awid_o    (awid),
    .outport_awlen_o   (awlen),
    .outport_awburst_o (awburst),
    .outport_wvalid_o  (wvalid),
    .outport_wdata_o   (wdata),
    .outport_wstrb_o   (wstrb),
    .outport_wlast_o   (wlast),
    .outport_bready_o  (bready)
  );

  // Contents of the simulated SDRAM at a byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_00C3;
  endfunction

  task automatic chk1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, req);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Reference: split a line into page-safe bursts and list the words in order.
  function automatic void ref_line(input logic [31:0] base, input int unsigned words);
    logic [31:0] a;
    int unsigned left;
    a = base & ~32'h3;
    left = words;
    for (int i = 0; i < int'(words); i++) exp_pix.push_back(mem_word(a + 32'(4 * i)));
    while (left > 0) begin
      int unsigned page;
      int unsigned n;
      page = (4096 - (a % 4096)) / 4;
      n = Burst;
      if (left < n) n = left;
      if (page < n) n = page;
      exp_ar.push_back('{a, n});
      a = a + 32'(4 * n);
      left = left - n;
    end
  endfunction

  task automatic issue(input logic [31:0] base, input int unsigned words, input bit accepted);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = base;
    line_words = 16'(words);
    if (accepted) ref_line(base, words);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!(mon_idle && exp_ar.size() == 0 && (pop_mode == 0 || exp_pix.size() == 0))
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk1("line_completes_in_budget", n < budget, 1'b1);
  endtask

  // AXI read slave: one burst at a time, optional random stalls and error beat.
  initial begin : slave
    bit arf, rf, active;
    logic [31:0] cap_addr, baddr;
    int cap_beats, left, idx;
    active = 1'b0;
    left = 0;
    idx = 0;
    baddr = '0;
    forever begin
      @(negedge clk);
      arf = arvalid && arready;
      rf = rvalid && rready;
      cap_addr = araddr;
      cap_beats = int'(arlen) + 1;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        active = 1'b0;
        arready = 1'b0;
        rvalid = 1'b0;
        rlast = 1'b0;
        rresp = 2'b00;
      end else begin
        if (rf) begin
          idx++;
          left--;
          if (left == 0) active = 1'b0;
        end
        if (arf) begin
          active = 1'b1;
          baddr = cap_addr;
          left = cap_beats;
          idx = 0;
        end
        arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (active && !(rvalid && !rf)) begin
          rvalid = r_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
          rdata = mem_word(baddr + 32'(4 * idx));
          rlast = (left == 1);
          rresp = (beats_total == err_at) ? 2'b10 : 2'b00;
        end else if (!active) begin
          rvalid = 1'b0;
          rlast = 1'b0;
        end
      end
    end
  end

  // Consumer: always, random, or a fixed number of pops.
  initial begin : consumer
    forever begin
      @(posedge clk);
      #1;
      case (pop_mode)
        1:       pix_ready = 1'b1;
        2:       pix_ready = 1'($urandom_range(0, 1));
        default: pix_ready = (pop_total < pop_limit);
      endcase
    end
  end

  // Monitor: compares every observed transfer and status against the model.
  initial begin : monitor
    bit m_busy, m_err, done_due, next_done, accept, rf, pop;
    int words_left;
    burst_t b;
    m_busy = 1'b0;
    m_err = 1'b0;
    done_due = 1'b0;
    words_left = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_idle = 1'b1;
        occ = 0;
        m_busy = 1'b0;
        m_err = 1'b0;
        done_due = 1'b0;
        words_left = 0;
      end else begin
        rf = rvalid && rready;
        pop = pix_valid && pix_ready;
        if (rf && rresp != 2'b00) m_err = 1'b1;
        chk1("pix_valid", pix_valid, occ != 0);
        chk1("busy", busy, m_busy);
        chk1("done", done, done_due);
        chk1("err", err, m_err);
        if (arvalid && arready) begin
          ar_total++;
          if (exp_ar.size() == 0) begin
            total++;
            bad++;
            $display("FAIL ar_unexpected: got addr %0h arlen %0d, want no burst", araddr, arlen);
          end else begin
            b = exp_ar.pop_front();
            chk32("ar_addr", araddr, b.addr);
            chk32("ar_len", 32'(arlen), 32'(b.len - 1));
            chk32("ar_id", 32'(arid), 32'(Id));
            chk32("ar_burst", 32'(arburst), 32'd1);
            chk1("ar_fifo_space", (Depth - occ) >= (int'(arlen) + 1), 1'b1);
          end
        end
        if (pop) begin
          if (exp_pix.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pix_unexpected: got %0h, want no word", pix_data);
          end else begin
            chk32("pix_data", pix_data, exp_pix.pop_front());
          end
        end
        next_done = 1'b0;
        accept = start && mon_idle;
        if (done_due) mon_idle = 1'b1;
        if (rf) begin
          occ++;
          beats_total++;
          words_left--;
          if (words_left == 0) begin
            m_busy = 1'b0;
            next_done = 1'b1;
          end
        end
        if (pop) begin
          occ--;
          pop_total++;
        end
        if (accept) begin
          m_err = 1'b0;
          mon_idle = 1'b0;
          if (line_words == 16'd0) begin
            next_done = 1'b1;
          end else begin
            m_busy = 1'b1;
            words_left = int'(line_words);
          end
        end
        done_due = next_done;
      end
    end
  end

  initial begin : stimulus
    int a0, b0, n;
    #12;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_arvalid", arvalid, 1'b0);
    chk1("rst_rready", rready, 1'b0);
    chk1("rst_pix_valid", pix_valid, 1'b0);
    chk32("rst_araddr", araddr, 32'd0);
    chk32("rst_arlen", 32'(arlen), 32'd0);
    chk1("tie_awvalid", awvalid, 1'b0);
    chk1("tie_wvalid", wvalid, 1'b0);
    chk1("tie_bready", bready, 1'b1);
    #10;
    rst_n = 1'b1;

    // Page-aligned line split into 16/16/8.
    issue(32'h0000_1000, 40, 1'b1);
    wait_done(1000);

    // Line starting 8 bytes before a page boundary.
    issue(32'h0000_0FF8, 10, 1'b1);
    wait_done(1000);

    // Stalled consumer: FIFO space gates further bursts.
    pop_mode = 0;
    pop_limit = pop_total;
    a0 = ar_total;
    issue(32'h0000_2000, 80, 1'b1);
    repeat (150) @(negedge clk);
    chk32("fill_bursts", 32'(ar_total - a0), 32'd4);
    chk32("fill_level", 32'(occ), 32'd64);
    pop_limit = pop_total + 15;
    repeat (60) @(negedge clk);
    chk32("no_fifth_ar_at_15_free", 32'(ar_total - a0), 32'd4);
    pop_limit = pop_total + 1;
    repeat (20) @(negedge clk);
    chk32("fifth_ar_at_16_free", 32'(ar_total - a0), 32'd5);
    pop_mode = 1;
    wait_done(2000);

    // Error response on a beat: sticky until next start.
    err_at = beats_total + 3;
    issue(32'h0000_3000, 16, 1'b1);
    wait_done(1000);
    err_at = -1;
    chk1("err_sticky_after_done", err, 1'b1);
    repeat (5) @(negedge clk);
    chk1("err_sticky_idle", err, 1'b1);

    // Zero-length line, then a start ignored during an active fetch.
    a0 = ar_total;
    issue(32'h0000_4000, 0, 1'b1);
    wait_done(100);
    chk32("zero_len_no_ar", 32'(ar_total - a0), 32'd0);
    issue(32'h0000_4100, 20, 1'b1);
    repeat (5) @(negedge clk);
    issue(32'h0000_7000, 8, 1'b0);
    wait_done(1000);
    repeat (20) @(negedge clk);
    chk32("ignored_start_ar_count", 32'(ar_total - a0), 32'd2);

    // Random lines near page ends with random handshakes.
    ar_rand = 1'b1;
    r_rand = 1'b1;
    pop_mode = 2;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] base;
      base = 32'h0001_0000 + 32'($urandom_range(0, 15) * 4096)
             + 32'(4096 - 4 * $urandom_range(1, 40)) + 32'($urandom_range(0, 3));
      issue(base, $urandom_range(1, 70), 1'b1);
      wait_done(4000);
    end

    // Reset in the middle of a burst, then a clean 8-word fetch.
    b0 = beats_total;
    err_at = beats_total + 1;
    issue(32'h0000_5000, 40, 1'b1);
    n = 0;
    while (beats_total < b0 + 6 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk1("reached_mid_burst", n < 500, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_done", done, 1'b0);
    chk1("mid_rst_err", err, 1'b0);
    chk1("mid_rst_arvalid", arvalid, 1'b0);
    chk1("mid_rst_rready", rready, 1'b0);
    chk1("mid_rst_pix_valid", pix_valid, 1'b0);
    chk32("mid_rst_araddr", araddr, 32'd0);
    chk32("mid_rst_arlen", 32'(arlen), 32'd0);
    exp_ar.delete();
    exp_pix.delete();
    err_at = -1;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    ar_rand = 1'b0;
    r_rand = 1'b0;
    pop_mode = 1;
    issue(32'h0000_6004, 8, 1'b1);
    wait_done(1000);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
